// File: rtl/vga_controller_pkg.sv
// Shared VGA timing constants (640x480 @ 800x525 total) and a region decode helper.
package VGA_item_pack;

    localparam int COLOR_WIDTH = 4;
    localparam int CNT_W       = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FP,
        REG_SYNC,
        REG_BP
    } region_e;

    // Classifies one axis position; the back porch is whatever follows sync.
    function automatic region_e region_of(input logic [CNT_W-1:0] pos,
                                          input int act, input int fp, input int sync);
        if (pos < CNT_W'(act))
            return REG_ACTIVE;
        else if (pos < CNT_W'(act + fp))
            return REG_FP;
        else if (pos < CNT_W'(act + fp + sync))
            return REG_SYNC;
        else
            return REG_BP;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running h/v raster counters with region decode; held at 0,0 while disabled.
module vga_sync_counter
    import VGA_item_pack::*;
#(
    parameter int H_ACT   = H_ACTIVE,
    parameter int H_FRONT = H_FP,
    parameter int H_SYN   = H_SYNC,
    parameter int H_BACK  = H_BP,
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_SYN   = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             active,
    output logic             hsync_n,
    output logic             vsync_n
);

    localparam int H_TOT = H_ACT + H_FRONT + H_SYN + H_BACK;
    localparam int V_TOT = V_ACT + V_FRONT + V_SYN + V_BACK;

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    region_e          w_h_region;
    region_e          w_v_region;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == CNT_W'(H_TOT - 1)) begin
            r_h <= '0;
            r_v <= (r_v == CNT_W'(V_TOT - 1)) ? '0 : r_v + CNT_W'(1);
        end else begin
            r_h <= r_h + CNT_W'(1);
        end
    end

    assign w_h_region = region_of(r_h, H_ACT, H_FRONT, H_SYN);
    assign w_v_region = region_of(r_v, V_ACT, V_FRONT, V_SYN);

    assign h       = r_h;
    assign v       = r_v;
    assign active  = (w_h_region == REG_ACTIVE) && (w_v_region == REG_ACTIVE);
    assign hsync_n = (w_h_region != REG_SYNC);
    assign vsync_n = (w_v_region != REG_SYNC);

endmodule

// File: rtl/vga_controller.sv
// VGA output stage: pixel handshake, one-cycle registered sync/color aligned to the
// counter state, frame-start pulse and sticky underflow flag.
module vga_controller
    import VGA_item_pack::*;
#(
    parameter int COLOR_W = COLOR_WIDTH,
    parameter int H_ACT   = H_ACTIVE,
    parameter int H_FRONT = H_FP,
    parameter int H_SYN   = H_SYNC,
    parameter int H_BACK  = H_BP,
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_SYN   = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               pix_valid,
    input  logic [COLOR_W-1:0] pix_red,
    input  logic [COLOR_W-1:0] pix_green,
    input  logic [COLOR_W-1:0] pix_blue,
    output logic               pix_ready,
    input  logic               underflow_clr,
    output logic               HSync,
    output logic               VSync,
    output logic [COLOR_W-1:0] RED,
    output logic [COLOR_W-1:0] GREEN,
    output logic [COLOR_W-1:0] BLUE,
    output logic               frame_start,
    output logic               underflow
);

    logic [CNT_W-1:0]   w_h;
    logic [CNT_W-1:0]   w_v;
    logic               w_active;
    logic               w_hsync_n;
    logic               w_vsync_n;
    logic               w_xfer;
    logic               w_miss;

    logic               r_hsync_p1;
    logic               r_vsync_p1;
    logic [COLOR_W-1:0] r_red_p1;
    logic [COLOR_W-1:0] r_green_p1;
    logic [COLOR_W-1:0] r_blue_p1;
    logic               r_fstart_p1;
    logic               r_underflow;

    vga_sync_counter #(
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .H_SYN   (H_SYN),
        .H_BACK  (H_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_SYN   (V_SYN),
        .V_BACK  (V_BACK)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .h       (w_h),
        .v       (w_v),
        .active  (w_active),
        .hsync_n (w_hsync_n),
        .vsync_n (w_vsync_n)
    );

    // rst_n gates ready so no pixel is consumed while the counters are being reset.
    assign pix_ready = rst_n && enable && w_active;
    assign w_xfer    = pix_ready && pix_valid;
    assign w_miss    = pix_ready && !pix_valid;

    // p0 -> p1: counter state and accepted pixel registered together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync_p1  <= 1'b1;
            r_vsync_p1  <= 1'b1;
            r_red_p1    <= '0;
            r_green_p1  <= '0;
            r_blue_p1   <= '0;
            r_fstart_p1 <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (!enable) begin
                r_hsync_p1  <= 1'b1;
                r_vsync_p1  <= 1'b1;
                r_red_p1    <= '0;
                r_green_p1  <= '0;
                r_blue_p1   <= '0;
                r_fstart_p1 <= 1'b0;
            end else begin
                r_hsync_p1  <= w_hsync_n;
                r_vsync_p1  <= w_vsync_n;
                r_red_p1    <= w_xfer ? pix_red   : '0;
                r_green_p1  <= w_xfer ? pix_green : '0;
                r_blue_p1   <= w_xfer ? pix_blue  : '0;
                r_fstart_p1 <= (w_h == '0) && (w_v == '0);
            end
            // A new miss outranks a simultaneous clear.
            if (w_miss)
                r_underflow <= 1'b1;
            else if (underflow_clr)
                r_underflow <= 1'b0;
        end
    end

    assign HSync       = r_hsync_p1;
    assign VSync       = r_vsync_p1;
    assign RED         = r_red_p1;
    assign GREEN       = r_green_p1;
    assign BLUE        = r_blue_p1;
    assign frame_start = r_fstart_p1;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench: full-size controller plus a shrunken-timing instance so vertical
// sync and mid-frame reset during VSync are reachable in a short run.
module tb_vga_controller;
    import VGA_item_pack::*;

    localparam int CW   = COLOR_WIDTH;
    localparam int S_HA = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 2;
    localparam int S_VA = 4;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          pix_valid;
    logic          underflow_clr;
    logic [CW-1:0] pix_red, pix_green, pix_blue;

    logic          pix_ready, HSync, VSync, frame_start, underflow;
    logic [CW-1:0] RED, GREEN, BLUE;
    logic          s_pix_ready, s_HSync, s_VSync, s_frame_start, s_underflow;
    logic [CW-1:0] s_RED, s_GREEN, s_BLUE;

    int checks = 0;
    int errors = 0;
    int mh, mv, sh, sv, idx;
    logic muf, suf;
    int win, fs_cnt, hs_low, hs_first, rdy_cnt;
    int s_fs_cnt, s_hs_low, s_vs_low, s_vs_first;

    always #5 clk = ~clk;

    vga_controller dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
        .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
        .pix_ready(pix_ready), .underflow_clr(underflow_clr),
        .HSync(HSync), .VSync(VSync), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
        .frame_start(frame_start), .underflow(underflow)
    );

    vga_controller #(
        .H_ACT(S_HA), .H_FRONT(S_HF), .H_SYN(S_HS), .H_BACK(S_HB),
        .V_ACT(S_VA), .V_FRONT(S_VF), .V_SYN(S_VS), .V_BACK(S_VB)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
        .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
        .pix_ready(s_pix_ready), .underflow_clr(underflow_clr),
        .HSync(s_HSync), .VSync(s_VSync), .RED(s_RED), .GREEN(s_GREEN), .BLUE(s_BLUE),
        .frame_start(s_frame_start), .underflow(s_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sync_n(input int pos, input int act, input int fp, input int sy);
        return !(pos >= act + fp && pos < act + fp + sy);
    endfunction

    task automatic clr_counts();
        win = 0; fs_cnt = 0; hs_low = 0; hs_first = -1; rdy_cnt = 0;
        s_fs_cnt = 0; s_hs_low = 0; s_vs_low = 0; s_vs_first = -1;
    endtask

    // One clock: drive inputs, check ready, predict both instances, check after the edge.
    task automatic cycle(input logic r, input logic en, input logic valid, input logic clr);
        logic m_rdy, s_rdy;
        logic [CW-1:0] cr, cg, cb;
        logic e_hs, e_vs, e_fs, se_hs, se_vs, se_fs;
        logic [CW-1:0] e_r, e_g, e_b, se_r, se_g, se_b;
        cr = CW'(idx); cg = ~CW'(idx); cb = CW'(idx + 3);
        rst_n = r; enable = en; pix_valid = valid; underflow_clr = clr;
        pix_red = cr; pix_green = cg; pix_blue = cb;
        m_rdy = r && en && mh < H_ACTIVE && mv < V_ACTIVE;
        s_rdy = r && en && sh < S_HA && sv < S_VA;
        #1;
        chk("pix_ready", pix_ready, m_rdy);
        chk("s_pix_ready", s_pix_ready, s_rdy);
        rdy_cnt += int'(pix_ready);

        e_hs = 1; e_vs = 1; e_fs = 0; e_r = '0; e_g = '0; e_b = '0;
        se_hs = 1; se_vs = 1; se_fs = 0; se_r = '0; se_g = '0; se_b = '0;
        if (r && en) begin
            e_hs = sync_n(mh, H_ACTIVE, H_FP, H_SYNC);
            e_vs = sync_n(mv, V_ACTIVE, V_FP, V_SYNC);
            e_fs = (mh == 0 && mv == 0);
            if (m_rdy && valid) begin e_r = cr; e_g = cg; e_b = cb; end
            se_hs = sync_n(sh, S_HA, S_HF, S_HS);
            se_vs = sync_n(sv, S_VA, S_VF, S_VS);
            se_fs = (sh == 0 && sv == 0);
            if (s_rdy && valid) begin se_r = cr; se_g = cg; se_b = cb; end
        end
        if (!r) begin muf = 0; suf = 0; end
        else begin
            if (m_rdy && !valid) muf = 1; else if (clr) muf = 0;
            if (s_rdy && !valid) suf = 1; else if (clr) suf = 0;
        end
        if (!r || !en) begin mh = 0; mv = 0; sh = 0; sv = 0; end
        else begin
            if (mh == H_TOTAL - 1) begin mh = 0; mv = (mv == V_TOTAL - 1) ? 0 : mv + 1; end
            else mh++;
            if (sh == S_HT - 1) begin sh = 0; sv = (sv == S_VT - 1) ? 0 : sv + 1; end
            else sh++;
        end
        if (m_rdy && valid) idx++;

        @(posedge clk); #1;
        chk("HSync", HSync, e_hs);
        chk("VSync", VSync, e_vs);
        chk("RED", RED, e_r);
        chk("GREEN", GREEN, e_g);
        chk("BLUE", BLUE, e_b);
        chk("frame_start", frame_start, e_fs);
        chk("underflow", underflow, muf);
        chk("s_HSync", s_HSync, se_hs);
        chk("s_VSync", s_VSync, se_vs);
        chk("s_RED", s_RED, se_r);
        chk("s_GREEN", s_GREEN, se_g);
        chk("s_BLUE", s_BLUE, se_b);
        chk("s_frame_start", s_frame_start, se_fs);
        chk("s_underflow", s_underflow, suf);

        fs_cnt += int'(frame_start);
        s_fs_cnt += int'(s_frame_start);
        if (!HSync) begin hs_low++; if (hs_first < 0) hs_first = win; end
        if (!s_HSync) s_hs_low++;
        if (!s_VSync) begin s_vs_low++; if (s_vs_first < 0) s_vs_first = win; end
        win++;
    endtask

    initial begin
        int guard;
        rst_n = 0; enable = 1; pix_valid = 1; underflow_clr = 0;
        pix_red = '0; pix_green = '0; pix_blue = '0;
        mh = 0; mv = 0; sh = 0; sv = 0; idx = 0; muf = 0; suf = 0;
        clr_counts();
        @(posedge clk); #1;

        // Reset held 5 cycles with valid asserted
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0);
        chk("rst_hsync", HSync, 1);
        chk("rst_vsync", VSync, 1);
        chk("rst_underflow", underflow, 0);

        // Ten full lines plus 100 pixels of line 10
        clr_counts();
        for (int k = 0; k < 8100; k++) begin
            cycle(1, 1, 1, 0);
            if (k == 20)  chk("line0_px20", RED, 4);
            if (k == 639) chk("line0_px639", RED, 15);
            if (k == 700) chk("line0_blank", RED, 0);
            if (k == 799) begin
                chk("line0_hs_first", hs_first, 656);
                chk("line0_hs_low", hs_low, 96);
                chk("line0_fs_cnt", fs_cnt, 1);
            end
        end
        chk("ready_cnt", rdy_cnt, 6500);
        chk("no_underflow_yet", underflow, 0);

        // Underflow at h=100, v=10, then clear, then clear colliding with a new miss
        cycle(1, 1, 0, 0);
        chk("uf_pixel", RED, 0);
        chk("uf_set", underflow, 1);
        cycle(1, 1, 1, 1);
        chk("uf_cleared", underflow, 0);
        cycle(1, 1, 0, 1);
        chk("uf_set_wins", underflow, 1);

        // Enable gap at h=300 on the same line
        for (int k = 0; k < 197; k++) cycle(1, 1, 1, 0);
        clr_counts();
        for (int k = 0; k < 10; k++) cycle(1, 0, 1, 0);
        chk("gap_fs", fs_cnt, 0);
        chk("gap_hs_low", hs_low, 0);
        chk("gap_red", RED, 0);
        chk("gap_keeps_uf", underflow, 1);
        clr_counts();
        cycle(1, 1, 1, 0);
        chk("reenable_fs", frame_start, 1);
        for (int k = 0; k < 799; k++) cycle(1, 1, 1, 0);
        chk("reenable_fs_cnt", fs_cnt, 1);
        chk("reenable_hs_first", hs_first, 656);
        chk("reenable_hs_low", hs_low, 96);

        // Mid-line reset at h=700
        for (int k = 0; k < 700; k++) cycle(1, 1, 1, 0);
        cycle(0, 1, 1, 0);
        chk("midrst_hsync", HSync, 1);
        chk("midrst_uf", underflow, 0);
        cycle(1, 1, 1, 0);
        chk("midrst_fs", frame_start, 1);

        // Small instance: reset during VSync, then two full frames
        guard = 0;
        while (!(sv == 5 && sh == 12) && guard < 300) begin
            cycle(1, 1, 1, 0);
            guard++;
        end
        chk("s_reach_vsync", guard < 300, 1);
        chk("s_vsync_low", s_VSync, 0);
        cycle(0, 1, 1, 0);
        chk("s_rst_vsync", s_VSync, 1);
        clr_counts();
        cycle(1, 1, 1, 0);
        chk("s_rst_fs", s_frame_start, 1);
        for (int k = 0; k < 239; k++) cycle(1, 1, 1, 0);
        chk("s_fs_cnt", s_fs_cnt, 2);
        chk("s_vs_low", s_vs_low, 60);
        chk("s_vs_first", s_vs_first, 75);
        chk("s_hs_low", s_hs_low, 48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 SHALL: clock port `clk` and reset port `rst_n`; one clock; reset synchronous, active-low.
REQ-002 SHALL: parameter `COLOR_W`, default `COLOR_WIDTH` from `VGA_item_pack`, per-channel color width.
REQ-003 SHALL provide these ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  synchronous active-low reset.
- `enable`  in  1  1 = run timing; 0 = hold idle.
- `pix_valid`  in  1  upstream pixel available.
- `pix_red`, `pix_green`, `pix_blue`  in  `COLOR_W` each  upstream pixel color.
- `pix_ready`  out  1  controller consumes a pixel this cycle.
- `underflow_clr`  in  1  clears the underflow flag.
- `HSync`  out  1  horizontal sync, active-low.
- `VSync`  out  1  vertical sync, active-low.
- `RED`, `GREEN`, `BLUE`  out  `COLOR_W` each  display color.
- `frame_start`  out  1  one-cycle pulse on the first active pixel of a frame.
- `underflow`  out  1  sticky flag: an active pixel was missing.

Function
REQ-004 SHALL keep horizontal counter h in 0..`H_TOTAL`-1 (800); h wraps to 0 after 799 and then increments v.
REQ-005 SHALL keep vertical counter v in 0..`V_TOTAL`-1 (525); v wraps to 0 after h=799, v=524.
REQ-006 SHALL use these timings, in counter values:
- h active 0..639; H front porch 16; HSync low for h 656..751; H back porch 48.
- v active 0..479; V front porch 10; VSync low for v 490..491; V back porch 33.
REQ-007 SHALL drive `pix_ready` combinationally: 1 iff `enable`=1 and h<640 and v<480.
REQ-008 SHALL follow valid/ready rules: a pixel transfers when `pix_valid` and `pix_ready` are both 1. Upstream SHALL hold data stable while `pix_valid`=1 and `pix_ready`=0.
REQ-009 SHALL register all outputs. `HSync`, `VSync`, `RED`/`GREEN`/`BLUE` and `frame_start` reflect the counter state of the previous cycle (latency 1), so sync and color stay aligned.
REQ-010 SHALL register the transferred pixel onto `RED`/`GREEN`/`BLUE`. All three are 0 during blanking.
REQ-011 SHALL handle a missing active pixel: when `pix_ready`=1 and `pix_valid`=0, the next-cycle color is 0 and `underflow` sets. h/v advance anyway; timing never stalls.
REQ-012 SHALL clear `underflow` only on `underflow_clr`=1 or reset. If set and clear occur in the same cycle, set wins.
REQ-013 SHALL assert `frame_start` for exactly one cycle, in the output cycle corresponding to h=0, v=0.
REQ-014 SHALL handle `enable`: when 0, h and v load 0 next cycle, and outputs go to `HSync`=1, `VSync`=1, color 0, `frame_start`=0. When `enable` rises, counting starts at h=0, v=0, and `frame_start` pulses one cycle later.
REQ-015 SHALL NOT change `underflow` on `enable` changes.

Reset
REQ-016 SHALL, while `rst_n`=0 at a `clk` edge, set:
- h=0, v=0;
- `HSync`=1, `VSync`=1;
- `RED`=`GREEN`=`BLUE`=0;
- `frame_start`=0, `underflow`=0.
REQ-017 SHALL hold `pix_ready`=0 during reset.
REQ-018 SHALL, on reset mid-frame, abandon the frame. After `rst_n` returns to 1 with `enable`=1, a new frame starts from h=0, v=0.

Structure
REQ-019 SHALL place these constants in shared package `VGA_item_pack`, alongside `COLOR_WIDTH`:
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, `H_TOTAL`;
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, `V_TOTAL`.
REQ-020 SHALL implement h/v counting and region decode in one sub-module, `vga_sync_counter`, with outputs h, v, active, hsync_n, vsync_n. `vga_controller` SHALL contain the handshake, output registers and flags.

Verification
REQ-021 SHALL cover reset: hold `rst_n`=0 for 5 cycles with `pix_valid`=1 -> `HSync`=`VSync`=1, color 0, `pix_ready`=0, `underflow`=0 throughout.
REQ-022 SHALL cover full-frame timing: `enable`=1 and constant `pix_valid`=1 for 420000 cycles -> per line, `HSync` low for exactly 96 cycles starting 656 cycles after line start. Per frame, `VSync` low for exactly 2 lines (1600 cycles). Period = 800×525 cycles.
REQ-023 SHALL cover data path: upstream drives an incrementing pattern (R=G=B=index mod 16) -> output line 0 shows pixels 0..15 repeating for 640 cycles, then 160 cycles of 0. `pix_ready` is high exactly 307200 cycles per frame.
REQ-024 SHALL cover underflow: drop `pix_valid` for 1 cycle at h=100, v=10 -> that output pixel is 0 and `underflow`=1 from the next cycle. Pulse `underflow_clr` -> `underflow`=0. Assert clear in the same cycle as a new underflow -> `underflow` stays 1.
REQ-025 SHALL cover `enable` toggling: deassert `enable` at h=300, v=200 for 10 cycles, then reassert -> outputs idle during the gap. `frame_start` pulses exactly once, 1 cycle after re-enable, and `HSync` timing restarts from h=0.
REQ-026 SHALL cover mid-frame reset: pulse `rst_n`=0 for 1 cycle at h=700, v=490 (`VSync` low) -> `VSync`=1 next cycle, and the new frame begins with `frame_start` after release.
